operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader.sv | 103 ++++++++++
 tb/tb_operand_loader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// Collects DEPTH switch operands on button presses, then streams them downstream
// with a valid/ready handshake; flags presses that arrive while streaming.
module operand_loader #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             cpu_reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_click,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [2:0]       count,
  output logic             busy,
  output logic             overrun,
  output logic [31:0]      digits
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WIDTH < 16) ? WIDTH : 16;

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]       state;
  logic [2:0]       rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [15:0]      sw16;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_nxt;
  logic             wr_en;
  logic             last;

  always_comb begin
    sw16 = '0;
    sw16[CW-1:0] = sw[CW-1:0];
  end

  // DONE restarts a batch at slot 0, so the write index follows the state.
  assign wr_idx = (state == S_DONE) ? '0 : count[AW-1:0];
  assign wr_en  = btn_click && ((state == S_COLLECT) || (state == S_DONE));
  assign rd_nxt = AW'(rd_ptr + 3'd1);
  assign last   = (rd_ptr == 3'(DEPTH - 1));

  // Operand storage carries no reset; contents are always rewritten before use.
  always_ff @(posedge clk) begin
    if (cpu_reset && wr_en) mem[wr_idx] <= sw;
  end

  always_ff @(posedge clk) begin
    if (!cpu_reset) begin
      state      <= S_COLLECT;
      count      <= '0;
      rd_ptr     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      digits     <= '0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (btn_click) begin
            count  <= count + 3'd1;
            digits <= {13'b0, count + 3'd1, sw16};
            if (count == 3'(DEPTH - 1)) begin
              state      <= S_SEND;
              busy       <= 1'b1;
              data_valid <= 1'b1;
              data_out   <= mem[0];
              rd_ptr     <= '0;
            end
          end
        end
        S_SEND: begin
          if (btn_click) overrun <= 1'b1;
          if (data_valid && out_ready) begin
            if (last) begin
              data_valid <= 1'b0;
              busy       <= 1'b0;
              state      <= S_DONE;
            end else begin
              rd_ptr   <= rd_ptr + 3'd1;
              data_out <= mem[rd_nxt];
            end
          end
        end
        S_DONE: begin
          if (btn_click) begin
            count   <= 3'd1;
            overrun <= 1'b0;
            digits  <= {13'b0, 3'd1, sw16};
            state   <= S_COLLECT;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: captured words are queued at press time
// and checked as they are handshaken out.
module tb_operand_loader;
  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             cpu_reset;
  logic [WIDTH-1:0] sw;
  logic             btn_click;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic [2:0]       count;
  logic             busy;
  logic             overrun;
  logic [31:0]      digits;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q [$];

  always #5 clk = ~clk;

  operand_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .cpu_reset(cpu_reset), .sw(sw), .btn_click(btn_click),
    .out_ready(out_ready), .data_out(data_out), .data_valid(data_valid),
    .count(count), .busy(busy), .overrun(overrun), .digits(digits)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; the monitor samples at the falling edge.
  always @(negedge clk) begin
    if (cpu_reset === 1'b1 && data_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_word", {16'h0, data_out}, 32'hFFFF_FFFF);
      else chk("stream_word", {16'h0, data_out}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [WIDTH-1:0] v, input bit expect_capture);
    sw = v;
    btn_click = 1'b1;
    if (expect_capture) exp_q.push_back(v);
    step();
    btn_click = 1'b0;
  endtask

  initial begin
    cpu_reset = 1'b0; sw = '0; btn_click = 1'b0; out_ready = 1'b0;
    step(); step();
    chk("rst_valid",   {31'h0, data_valid}, 32'h0);
    chk("rst_data",    {16'h0, data_out},   32'h0);
    chk("rst_count",   {29'h0, count},      32'h0);
    chk("rst_busy",    {31'h0, busy},       32'h0);
    chk("rst_overrun", {31'h0, overrun},    32'h0);
    chk("rst_digits",  digits,              32'h0);

    // Fill batch 1; presses back-to-back model a held button.
    cpu_reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      press(WIDTH'(i), 1'b1);
      chk("fill_count", {29'h0, count}, 32'(i));
      chk("fill_digits", digits, {13'h0, 3'(i), 16'(i)});
    end
    chk("fill_valid", {31'h0, data_valid}, 32'h1);
    chk("fill_data",  {16'h0, data_out},   32'h0001);
    chk("fill_busy",  {31'h0, busy},       32'h1);

    // Continuous stream.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("stream_done_valid", {31'h0, data_valid}, 32'h0);
    chk("stream_done_busy",  {31'h0, busy},       32'h0);
    chk("stream_done_count", {29'h0, count},      32'h4);
    chk("stream_q_empty",    32'(exp_q.size()),   32'h0);

    // Restart from DONE; out_ready must be ignored there.
    step();
    chk("done_hold_count", {29'h0, count}, 32'h4);
    out_ready = 1'b0;
    press(16'h00AA, 1'b1);
    chk("restart_count",   {29'h0, count},   32'h1);
    chk("restart_overrun", {31'h0, overrun}, 32'h0);
    chk("restart_digits",  digits,           32'h0001_00AA);
    chk("restart_busy",    {31'h0, busy},    32'h0);
    press(16'h0011, 1'b1);
    press(16'h0022, 1'b1);
    press(16'h0033, 1'b1);
    chk("b2_busy", {31'h0, busy}, 32'h1);

    // One transfer, then backpressure with an ignored press.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    press(16'hBEEF, 1'b0);
    chk("overrun_set",    {31'h0, overrun}, 32'h1);
    chk("overrun_digits", digits,           32'h0004_0033);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", {31'h0, data_valid}, 32'h1);
      chk("bp_data",  {16'h0, data_out},   32'h0011);
      if (i < 2) step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("b2_done_valid",  {31'h0, data_valid}, 32'h0);
    chk("b2_q_empty",     32'(exp_q.size()),   32'h0);
    chk("overrun_sticky", {31'h0, overrun},    32'h1);

    // Reset after the second streamed word of batch 3.
    out_ready = 1'b0;
    press(16'h0101, 1'b1);
    chk("b3_overrun_clr", {31'h0, overrun}, 32'h0);
    press(16'h0202, 1'b1);
    press(16'h0303, 1'b1);
    press(16'h0404, 1'b1);
    out_ready = 1'b1;
    step(); step();
    cpu_reset = 1'b0;
    btn_click = 1'b1; sw = 16'h5555;
    exp_q.delete();
    step();
    btn_click = 1'b0;
    chk("mid_rst_valid",  {31'h0, data_valid}, 32'h0);
    chk("mid_rst_data",   {16'h0, data_out},   32'h0);
    chk("mid_rst_count",  {29'h0, count},      32'h0);
    chk("mid_rst_busy",   {31'h0, busy},       32'h0);
    chk("mid_rst_digits", digits,              32'h0);
    cpu_reset = 1'b1;
    step();
    chk("post_rst_novalid", {31'h0, data_valid}, 32'h0);

    // New batch with out_ready already high.
    press(16'hA001, 1'b1);
    chk("post_rst_count", {29'h0, count}, 32'h1);
    press(16'hA002, 1'b1);
    press(16'hA003, 1'b1);
    press(16'hA004, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("b4_done_valid", {31'h0, data_valid}, 32'h0);
    chk("b4_q_empty",    32'(exp_q.size()),   32'h0);
    chk("b4_digits",     digits,              32'h0004_A004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
